// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the pipeline and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, abort, hi_we, lo_we, wd,
    input  busy, done, dbz, hi, lo
  );

  modport slave (
    input  start, op, a, b, abort, hi_we, lo_we, wd,
    output busy, done, dbz, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit owning the architectural HI/LO registers.
// Signed operations run on magnitudes and the result signs are applied in a final fixup cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StIter, StFixup} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic               is_div_q;
  logic               neg_main_q;  // product / quotient sign
  logic               neg_rem_q;   // remainder sign
  logic               dbz_pend_q;
  logic [WIDTH-1:0]   acc_hi_q;    // partial product high half / partial remainder
  logic [WIDTH-1:0]   acc_lo_q;    // multiplier bits / dividend shifting into quotient
  logic [WIDTH-1:0]   opnd_q;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q, dbz_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes, one iteration step, and sign fixup of the finished result.
  always_comb begin
    a_mag    = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag    = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_diff = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opnd_q};
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_main_q ? -prod : prod;
    // A zero divisor leaves the dividend magnitude in the remainder, so negating by the
    // dividend sign restores the raw dividend; only the quotient needs forcing.
    quo_fix  = dbz_pend_q ? '1 : (neg_main_q ? -acc_lo_q : acc_lo_q);
    rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;
  end

  // Control FSM, iteration datapath and HI/LO result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            is_div_q   <= bus.op[1];
            neg_main_q <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem_q  <= bus.op[0] & bus.a[WIDTH-1];
            dbz_pend_q <= bus.op[1] && (bus.b == '0);
            acc_hi_q   <= '0;
            acc_lo_q   <= a_mag;
            opnd_q     <= b_mag;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= StIter;
          end else begin
            if (bus.hi_we) hi_q <= bus.wd;
            if (bus.lo_we) lo_q <= bus.wd;
          end
        end
        StIter: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            if (is_div_q) begin
              // Restoring step: keep the difference only when it did not borrow.
              if (!div_diff[WIDTH]) begin
                acc_hi_q <= div_diff[WIDTH-1:0];
                acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b1};
              end else begin
                acc_hi_q <= {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
                acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b0};
              end
            end else begin
              {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFixup;
          end
        end
        StFixup: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
          if (!bus.abort) begin
            if (is_div_q) begin
              hi_q  <= rem_fix;
              lo_q  <= quo_fix;
              dbz_q <= dbz_pend_q;
            end else begin
              {hi_q, lo_q} <= prod_fix;
              dbz_q        <= 1'b0;
            end
            done_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized operations
// compared against a 64-bit arithmetic reference model.
module tb_muldiv_unit;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus_if ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  // Reference results straight from the arithmetic definition of each op.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dbz);
    logic [63:0] up;
    longint      sa, sb, sp;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    case (op)
      2'b00: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
      2'b01: begin sp = sa * sb; up = sp; hi = up[63:32]; lo = up[31:0]; end
      2'b10: begin
        if (b == 0) begin dbz = 1'b1; lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: begin
        if (b == 0) begin dbz = 1'b1; lo = '1; hi = a; end
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
    endcase
  endfunction

  // Issue one op from a negedge and wait (bounded) for done; returns cycles from the
  // start edge to the done cycle and the number of busy cycles seen in between.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n);
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.a     = a;
    bus_if.b     = b;
    @(negedge clk);
    bus_if.start = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (bus_if.done !== 1'b1 && lat < 100) begin
      if (bus_if.busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    bus_if.start = 0; bus_if.op = 0; bus_if.a = 0; bus_if.b = 0; bus_if.abort = 0;
    bus_if.hi_we = 0; bus_if.lo_we = 0; bus_if.wd = 0;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus_if.busy, bus_if.done, bus_if.dbz, bus_if.hi, bus_if.lo} !== '0)
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h want all zero",
               bus_if.busy, bus_if.done, bus_if.dbz, bus_if.hi, bus_if.lo);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0)
      $display("FAIL reset_release: got busy=%b done=%b want 0 0", bus_if.busy, bus_if.done);
    else n_pass++;
  endtask

  task automatic test_multu();
    int lat, bn;
    @(negedge clk);
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bn);
    n_checks++;
    if (bus_if.hi !== 32'hFFFFFFFE) $display("FAIL multu_hi: got %h want fffffffe", bus_if.hi);
    else n_pass++;
    n_checks++;
    if (bus_if.lo !== 32'h00000001) $display("FAIL multu_lo: got %h want 00000001", bus_if.lo);
    else n_pass++;
    n_checks++;
    if (lat != 33) $display("FAIL multu_latency: got %0d want 33", lat);
    else n_pass++;
    n_checks++;
    if (bn != 33) $display("FAIL multu_busy_cycles: got %0d want 33", bn);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus_if.done !== 1'b0) $display("FAIL done_pulse_width: got done=%b want 0", bus_if.done);
    else n_pass++;
  endtask

  task automatic test_mult();
    int lat, bn;
    @(negedge clk);
    run_op(2'b01, 32'hFFFFFFFD, 32'd7, lat, bn);
    n_checks++;
    if ({bus_if.hi, bus_if.lo} !== 64'hFFFFFFFF_FFFFFFEB)
      $display("FAIL mult_neg: got %h_%h want ffffffff_ffffffeb", bus_if.hi, bus_if.lo);
    else n_pass++;
    @(negedge clk);
    run_op(2'b01, 32'h80000000, 32'h80000000, lat, bn);
    n_checks++;
    if ({bus_if.hi, bus_if.lo} !== 64'h40000000_00000000)
      $display("FAIL mult_minneg: got %h_%h want 40000000_00000000", bus_if.hi, bus_if.lo);
    else n_pass++;
  endtask

  task automatic test_div();
    int lat, bn;
    @(negedge clk);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, lat, bn);
    n_checks++;
    if (bus_if.lo !== 32'hFFFFFFFD || bus_if.hi !== 32'hFFFFFFFF)
      $display("FAIL div_neg: got lo=%h hi=%h want lo=fffffffd hi=ffffffff", bus_if.lo, bus_if.hi);
    else n_pass++;
    // Issued in the done cycle of the previous op.
    run_op(2'b10, 32'd100, 32'd7, lat, bn);
    n_checks++;
    if (bus_if.lo !== 32'd14 || bus_if.hi !== 32'd2)
      $display("FAIL divu_b2b: got lo=%0d hi=%0d want lo=14 hi=2", bus_if.lo, bus_if.hi);
    else n_pass++;
    n_checks++;
    if (lat != 33) $display("FAIL b2b_latency: got %0d want 33", lat);
    else n_pass++;
  endtask

  task automatic test_dbz();
    int lat, bn;
    @(negedge clk);
    run_op(2'b10, 32'h1234, 32'h0, lat, bn);
    n_checks++;
    if (bus_if.lo !== 32'hFFFFFFFF || bus_if.hi !== 32'h1234 || bus_if.dbz !== 1'b1)
      $display("FAIL divu_by_zero: got lo=%h hi=%h dbz=%b want ffffffff 00001234 1",
               bus_if.lo, bus_if.hi, bus_if.dbz);
    else n_pass++;
    n_checks++;
    if (lat != 33) $display("FAIL dbz_latency: got %0d want 33", lat);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus_if.dbz !== 1'b1) $display("FAIL dbz_hold: got %b want 1", bus_if.dbz);
    else n_pass++;
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, bn);
    n_checks++;
    if (bus_if.lo !== 32'h80000000 || bus_if.hi !== 32'h0 || bus_if.dbz !== 1'b0)
      $display("FAIL div_overflow: got lo=%h hi=%h dbz=%b want 80000000 00000000 0",
               bus_if.lo, bus_if.hi, bus_if.dbz);
    else n_pass++;
    @(negedge clk);
    run_op(2'b11, 32'hFFFFFFF0, 32'h0, lat, bn);
    n_checks++;
    if (bus_if.lo !== 32'hFFFFFFFF || bus_if.hi !== 32'hFFFFFFF0 || bus_if.dbz !== 1'b1)
      $display("FAIL div_by_zero_signed: got lo=%h hi=%h dbz=%b want ffffffff fffffff0 1",
               bus_if.lo, bus_if.hi, bus_if.dbz);
    else n_pass++;
  endtask

  task automatic test_direct_abort();
    int done_seen;
    @(negedge clk);
    bus_if.hi_we = 1'b1; bus_if.wd = 32'hA5A5A5A5;
    @(negedge clk);
    bus_if.hi_we = 1'b0;
    n_checks++;
    if (bus_if.hi !== 32'hA5A5A5A5) $display("FAIL hi_we: got %h want a5a5a5a5", bus_if.hi);
    else n_pass++;
    bus_if.lo_we = 1'b1; bus_if.wd = 32'h5A5A1234;
    @(negedge clk);
    bus_if.lo_we = 1'b0;
    n_checks++;
    if (bus_if.lo !== 32'h5A5A1234 || bus_if.hi !== 32'hA5A5A5A5)
      $display("FAIL lo_we: got lo=%h hi=%h want 5a5a1234 a5a5a5a5", bus_if.lo, bus_if.hi);
    else n_pass++;
    // Write in the same cycle as an accepted start is dropped.
    bus_if.start = 1'b1; bus_if.op = 2'b00; bus_if.a = 32'd3; bus_if.b = 32'd5;
    bus_if.hi_we = 1'b1; bus_if.wd = 32'hDEADBEEF;
    @(negedge clk);
    bus_if.start = 1'b0; bus_if.hi_we = 1'b0;
    n_checks++;
    if (bus_if.hi !== 32'hA5A5A5A5 || bus_if.busy !== 1'b1)
      $display("FAIL we_with_start: got hi=%h busy=%b want a5a5a5a5 1", bus_if.hi, bus_if.busy);
    else n_pass++;
    repeat (4) @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = 2'b10; bus_if.a = 32'd100; bus_if.b = 32'd7;
    bus_if.lo_we = 1'b1; bus_if.wd = 32'h11111111;
    @(negedge clk);
    bus_if.start = 1'b0; bus_if.lo_we = 1'b0;
    n_checks++;
    if (bus_if.lo !== 32'h5A5A1234 || bus_if.hi !== 32'hA5A5A5A5)
      $display("FAIL we_while_busy: got lo=%h hi=%h want 5a5a1234 a5a5a5a5", bus_if.lo, bus_if.hi);
    else n_pass++;
    repeat (4) @(negedge clk);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    n_checks++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.hi !== 32'hA5A5A5A5 ||
        bus_if.lo !== 32'h5A5A1234)
      $display("FAIL abort: got busy=%b done=%b hi=%h lo=%h want 0 0 a5a5a5a5 5a5a1234",
               bus_if.busy, bus_if.done, bus_if.hi, bus_if.lo);
    else n_pass++;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) $display("FAIL abort_quiet: got %0d active cycles want 0", done_seen);
    else n_pass++;
    // abort in idle is inert.
    bus_if.abort = 1'b1; bus_if.hi_we = 1'b1; bus_if.wd = 32'hCAFEF00D;
    @(negedge clk);
    bus_if.abort = 1'b0; bus_if.hi_we = 1'b0;
    n_checks++;
    if (bus_if.hi !== 32'hCAFEF00D) $display("FAIL abort_idle: got %h want cafef00d", bus_if.hi);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int lat, bn;
    @(negedge clk);
    run_op(2'b10, 32'h1234, 32'h0, lat, bn);
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = 2'b11; bus_if.a = 32'hFFFFFFF9; bus_if.b = 32'd2;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (bus_if.busy !== 1'b1 || bus_if.dbz !== 1'b1)
      $display("FAIL pre_reset_busy: got busy=%b dbz=%b want 1 1", bus_if.busy, bus_if.dbz);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus_if.busy, bus_if.done, bus_if.dbz, bus_if.hi, bus_if.lo} !== '0)
      $display("FAIL async_reset: got busy=%b done=%b dbz=%b hi=%h lo=%h want all zero",
               bus_if.busy, bus_if.done, bus_if.dbz, bus_if.hi, bus_if.lo);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(2'b00, 32'd3, 32'd5, lat, bn);
    n_checks++;
    if (bus_if.lo !== 32'd15 || bus_if.hi !== 32'd0 || lat != 33)
      $display("FAIL post_reset_multu: got lo=%0d hi=%0d lat=%0d want 15 0 33",
               bus_if.lo, bus_if.hi, lat);
    else n_pass++;
  endtask

  task automatic test_random();
    int          lat, bn;
    logic [1:0]  op;
    logic [31:0] a, b, ehi, elo;
    logic        edbz;
    for (int i = 0; i < 48; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 20);
        3: a = 32'h80000000;
        default: ;
      endcase
      model(op, a, b, ehi, elo, edbz);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_op(op, a, b, lat, bn);
      n_checks++;
      if (bus_if.hi !== ehi || bus_if.lo !== elo || bus_if.dbz !== edbz || lat != 33)
        $display("FAIL random_%0d op=%0d a=%h b=%h: got hi=%h lo=%h dbz=%b lat=%0d want %h %h %b 33",
                 i, op, a, b, bus_if.hi, bus_if.lo, bus_if.dbz, lat, ehi, elo, edbz);
      else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_dbz();
    test_direct_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
